toll_accum_arbiter: RTL and testbench
=====================================

Name: toll_accum_arbiter

Overview:
- Shares one 4-digit BCD toll-total accumulator between two booth lanes.
- Each lane presents its classified vehicle charge as binary 0..99 with a request.
- The block grants lanes round-robin and converts the winning charge to BCD.
- It adds the charge one digit per cycle into the running total, which feeds the HEX0..HEX3 display path directly.

Parameters:
- CNT_W, 8, width of the per-lane transaction counters.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2  per-lane request; bit i = lane i. Held until the matching ack.
- val0  input  8  lane 0 charge, binary; must be stable while req[0] is high.
- val1  input  8  lane 1 charge, binary; must be stable while req[1] is high.
- clr  input  1  synchronous clear request for the total, overflow and counters.
- ack  output  2  one-cycle grant/capture pulse per lane.
- busy  output  1  high while an addition is in progress.
- total_bcd  output  16  accumulated total, 4 BCD digits, [3:0] = units.
- total_valid  output  1  high when total_bcd is stable (equals ~busy).
- overflow  output  1  sticky; set on carry out of the thousands digit.
- err  output  1  one-cycle pulse when a captured charge is greater than 99.
- cnt0  output  CNT_W  lane 0 accepted transactions, saturating.
- cnt1  output  CNT_W  lane 1 accepted transactions, saturating.

Behaviour:
- Reset (async, rst_n low): state=IDLE, total_bcd=0, overflow=0, ack=0, err=0, busy=0, cnt0=cnt1=0, last-served pointer=lane 1 (lane 0 wins first), pending-clear=0.
- States: IDLE, CONV, ADD0, ADD1, ADD2, ADD3.
- IDLE, clear path: if clr or pending-clear is set, clear total_bcd, overflow, cnt0 and cnt1, and clear pending-clear. No grant is made that cycle; clear wins over req.
- IDLE, grant path: otherwise, if any req bit is high:
  - Winner = the only requester, or, if both request, the lane not last served.
  - At the edge: latch the winner's value and lane index, update the last-served pointer, drive ack[winner]=1 for exactly the next cycle, go to CONV.
- CONV (1 cycle):
  - If value > 99: pulse err, no add, counters unchanged, return to IDLE.
  - Else: split into tens and units BCD digits (units = v mod 10, tens = v / 10), increment the winner's counter (saturate at all-ones), go to ADD0.
- ADD0: d0 = d0 + units, producing a carry.
- ADD1: d1 = d1 + tens + carry.
- ADD2: d2 = d2 + carry.
- ADD3: d3 = d3 + carry.
- Digit add rule (every ADDn step): if sum ≥ 10, subtract 10 and carry = 1; otherwise carry = 0. Each digit is written in place at the end of its cycle.
- Leaving ADD3: if carry = 1, set overflow (total wraps modulo 10000). Then return to IDLE.
- Latency: ack pulse at cycle N+1 after a request sampled at edge N. Final total is visible with total_valid=1 at cycle N+6. One transaction per 6 cycles maximum.
- busy = 1 in CONV and ADD0..ADD3. total_bcd is only meaningful when busy=0.
- clr while busy sets pending-clear. The clear is applied in the first IDLE cycle, after the in-flight add completes. That add's counter increment is also cleared.
- A req dropped before its ack = request withdrawn, no effect. A req held after ack is treated as a new request in the next IDLE.
- Async reset mid-operation aborts immediately to reset values; a partially added total is discarded.
- A value of 0 is accepted normally: the counter increments and the total is unchanged.

Test Plan:
- Reset, then req[0] with val0=10 → ack[0] one cycle later; total_bcd=16'h0010, total_valid=1 six cycles after the request edge; cnt0=1.
- req=2'b11, val0=25, val1=50, both held → grant order lane 0, lane 1, lane 0, …; after two adds total=16'h0075. A third grant goes to lane 0 only once lane 1 has been served.
- Preload total to 0990 via a sequence of adds, then add 10 → carries ripple through all digits; total=16'h1000, overflow=0.
- Total 9990, add 50 → total=16'h0040, overflow=1 and stays sticky after further adds.
- val1=120 → ack[1], err pulse, total and cnt1 unchanged, next grant proceeds normally.
- clr asserted during ADD1 of a 25 add → the add completes, then the first IDLE cycle clears total, overflow and counters to 0. A request in that same cycle is granted on the following cycle.

Source files
------------

// File: rtl/toll_accum_arbiter.sv
`timescale 1ns/1ps
// Two-lane round-robin toll accumulator: grants one lane, converts its binary
// charge to BCD and ripples it into a 4-digit BCD running total one digit per cycle.
module toll_accum_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [7:0]       val0,
  input  logic [7:0]       val1,
  input  logic             clr,
  output logic [1:0]       ack,
  output logic             busy,
  output logic [15:0]      total_bcd,
  output logic             total_valid,
  output logic             overflow,
  output logic             err,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [2:0] {IDLE, CONV, ADD0, ADD1, ADD2, ADD3} state_t;

  state_t      state, state_nxt;
  logic        last;
  logic        pend;
  logic        carry;
  logic [7:0]  charge_p0;
  logic        lane_p0;
  logic [3:0]  tens_p1;
  logic [3:0]  units_p1;
  logic [4:0]  dsum;
  logic        win;
  logic        clr_now;
  logic        grant;
  logic        bad;

  // One BCD digit add: returns {carry, digit}.
  function automatic logic [4:0] bcd_add(input logic [3:0] a, input logic [3:0] b,
                                         input logic c);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, c};
    if (s >= 5'd10) return {1'b1, s[3:0] - 4'd10};
    else            return {1'b0, s[3:0]};
  endfunction

  // Binary 0..99 to {tens, units}; x*205>>11 equals x/10 over this range.
  function automatic logic [7:0] bin_to_bcd2(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(({8'd0, v} * 16'd205) >> 11);
    u = v[3:0] - t * 4'd10;
    return {t, u};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign busy        = (state != IDLE);
  assign total_valid = ~busy;
  assign clr_now     = clr | pend;
  assign win         = (req[0] & req[1]) ? ~last : req[1];
  assign grant       = (state == IDLE) && !clr_now && (|req);
  assign bad         = (charge_p0 > 8'd99);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = CONV;
      CONV:    state_nxt = bad ? IDLE : ADD0;
      ADD0:    state_nxt = ADD1;
      ADD1:    state_nxt = ADD2;
      ADD2:    state_nxt = ADD3;
      ADD3:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dsum = '0;
    case (state)
      ADD0:    dsum = bcd_add(total_bcd[3:0],   units_p1, 1'b0);
      ADD1:    dsum = bcd_add(total_bcd[7:4],   tens_p1,  carry);
      ADD2:    dsum = bcd_add(total_bcd[11:8],  4'd0,     carry);
      ADD3:    dsum = bcd_add(total_bcd[15:12], 4'd0,     carry);
      default: dsum = '0;
    endcase
  end

  // Control and architectural state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      total_bcd <= '0;
      overflow  <= 1'b0;
      ack       <= '0;
      err       <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
      last      <= 1'b1;
      pend      <= 1'b0;
      carry     <= 1'b0;
    end else begin
      state <= state_nxt;
      ack   <= '0;
      err   <= 1'b0;
      if (busy && clr) pend <= 1'b1;
      case (state)
        IDLE: begin
          if (clr_now) begin
            total_bcd <= '0;
            overflow  <= 1'b0;
            cnt0      <= '0;
            cnt1      <= '0;
            pend      <= 1'b0;
          end else if (|req) begin
            last <= win;
            ack  <= win ? 2'b10 : 2'b01;
          end
        end
        CONV: begin
          if (bad)          err  <= 1'b1;
          else if (lane_p0) cnt1 <= sat_inc(cnt1);
          else              cnt0 <= sat_inc(cnt0);
        end
        ADD0: begin
          total_bcd[3:0] <= dsum[3:0];
          carry          <= dsum[4];
        end
        ADD1: begin
          total_bcd[7:4] <= dsum[3:0];
          carry          <= dsum[4];
        end
        ADD2: begin
          total_bcd[11:8] <= dsum[3:0];
          carry           <= dsum[4];
        end
        ADD3: begin
          total_bcd[15:12] <= dsum[3:0];
          carry            <= 1'b0;
          if (dsum[4]) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // p0: captured charge and lane at grant; p1: BCD split in CONV
  always_ff @(posedge clk) begin
    if (grant) begin
      charge_p0 <= win ? val1 : val0;
      lane_p0   <= win;
    end
    if (state == CONV) {tens_p1, units_p1} <= bin_to_bcd2(charge_p0);
  end

endmodule

// File: tb/tb_toll_accum_arbiter.sv
`timescale 1ns/1ps
// Bench for toll_accum_arbiter: directed scenarios plus randomized traffic
// checked against an integer-arithmetic model of the toll total.
module tb_toll_accum_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [7:0]  val0;
  logic [7:0]  val1;
  logic        clr;
  logic [1:0]  ack;
  logic        busy;
  logic [15:0] total_bcd;
  logic        total_valid;
  logic        overflow;
  logic        err;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int checks = 0;
  int errors = 0;

  int m_total;
  int m_ovf;
  int m_cnt0;
  int m_cnt1;
  int m_last;

  toll_accum_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .val0(val0), .val1(val1), .clr(clr),
    .ack(ack), .busy(busy), .total_bcd(total_bcd), .total_valid(total_valid),
    .overflow(overflow), .err(err), .cnt0(cnt0), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int t);
    logic [15:0] r;
    r[15:12] = 4'((t / 1000) % 10);
    r[11:8]  = 4'((t / 100) % 10);
    r[7:4]   = 4'((t / 10) % 10);
    r[3:0]   = 4'(t % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_total"}, 32'(total_bcd), 32'(to_bcd(m_total)));
    chk({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, "_cnt0"},  32'(cnt0),      32'(m_cnt0));
    chk({tag, "_cnt1"},  32'(cnt1),      32'(m_cnt1));
  endtask

  task automatic model_clear();
    m_total = 0; m_ovf = 0; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // One request/transaction; caller is in an IDLE cycle, #1 after a clock edge.
  task automatic txn(input logic [1:0] r, input logic [7:0] v0, input logic [7:0] v1,
                     input bit clr_mid);
    int w;
    int v;
    int n;
    bit got;
    w = (r == 2'b11) ? ((m_last == 1) ? 0 : 1) : (r[1] ? 1 : 0);
    val0 = v0;
    val1 = v1;
    req  = r;
    got  = 0;
    n    = 0;
    while (n < 20 && !got) begin
      @(posedge clk); #1;
      n++;
      if (ack !== 2'b00) got = 1;
    end
    chk("ack_lane", 32'(ack), (w == 1) ? 32'd2 : 32'd1);
    chk("ack_latency", 32'(n), 32'd1);
    if (!got) begin
      req = 2'b00;
      return;
    end
    chk("busy_conv", 32'(busy), 32'd1);
    m_last = w;
    v = (w == 1) ? int'(v1) : int'(v0);
    @(posedge clk); #1;
    chk("err", 32'(err), (v > 99) ? 32'd1 : 32'd0);
    chk("ack_pulse", 32'(ack), 32'd0);
    if (v > 99) begin
      chk("busy_err", 32'(busy), 32'd0);
      chk_state("err");
      req = 2'b00;
      return;
    end
    if (w == 1) m_cnt1 = (m_cnt1 == 255) ? 255 : m_cnt1 + 1;
    else        m_cnt0 = (m_cnt0 == 255) ? 255 : m_cnt0 + 1;
    chk("busy_add0", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (clr_mid && k == 0) clr = 1'b1;
      if (clr_mid && k == 1) clr = 1'b0;
      chk("busy_add", 32'(busy), 32'd1);
    end
    if (m_total + v >= 10000) m_ovf = 1;
    m_total = (m_total + v) % 10000;
    @(posedge clk); #1;
    chk("busy_done", 32'(busy), 32'd0);
    chk("total_valid", 32'(total_valid), 32'd1);
    chk_state("done");
    req = 2'b00;
  endtask

  task automatic do_clear();
    clr  = 1'b1;
    req  = 2'b01;
    val0 = 8'd3;
    @(posedge clk); #1;
    clr = 1'b0;
    req = 2'b00;
    model_clear();
    chk("clr_ack", 32'(ack), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk_state("clr");
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; val0 = 8'd0; val1 = 8'd0; clr = 1'b0;
    model_clear();
    m_last = 1;
    #3;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(total_valid), 32'd1);
    chk_state("rst");
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // Both lanes held: round-robin starting with lane 0
    txn(2'b11, 8'd25, 8'd50, 0);
    txn(2'b11, 8'd25, 8'd50, 0);
    chk("rr_total75", 32'(total_bcd), 32'h0075);
    txn(2'b11, 8'd25, 8'd50, 0);

    do_clear();
    txn(2'b01, 8'd10, 8'd0, 0);
    chk("single_0010", 32'(total_bcd), 32'h0010);

    // Build 0990, then ripple to 1000
    do_clear();
    for (int i = 0; i < 10; i++) txn((i % 2 == 0) ? 2'b01 : 2'b10, 8'd99, 8'd99, 0);
    txn(2'b10, 8'd0, 8'd10, 0);
    chk("ripple_1000", 32'(total_bcd), 32'h1000);

    // Build 9990, then overflow
    for (int i = 0; i < 90; i++) txn(2'b01, 8'd99, 8'd0, 0);
    txn(2'b01, 8'd80, 8'd0, 0);
    chk("pre_9990", 32'(total_bcd), 32'h9990);
    txn(2'b10, 8'd0, 8'd50, 0);
    chk("wrap_0040", 32'(total_bcd), 32'h0040);
    chk("ovf_set", 32'(overflow), 32'd1);
    txn(2'b01, 8'd1, 8'd0, 0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Out-of-range charge, then normal traffic and a zero charge
    txn(2'b10, 8'd0, 8'd120, 0);
    txn(2'b10, 8'd0, 8'd7, 0);
    txn(2'b01, 8'd0, 8'd0, 0);

    // Clear during ADD1, with a request raised in the pending-clear IDLE cycle
    txn(2'b01, 8'd25, 8'd0, 1);
    req  = 2'b01;
    val0 = 8'd7;
    @(posedge clk); #1;
    model_clear();
    chk("pclr_ack", 32'(ack), 32'd0);
    chk_state("pclr");
    txn(2'b01, 8'd7, 8'd0, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [1:0] r;
      logic [7:0] a;
      logic [7:0] b;
      r = 2'($urandom_range(1, 3));
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 99));
      b = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 99));
      txn(r, a, b, 0);
    end

    // Asynchronous reset in the middle of an add
    txn(2'b01, 8'd5, 8'd0, 0);
    req  = 2'b01;
    val0 = 8'd33;
    @(posedge clk); #1;
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    m_last = 1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk_state("arst");
    #2 rst_n = 1'b1;
    txn(2'b11, 8'd5, 8'd6, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
